// File: rtl/axi_pkg.sv
// Shared AXI4 constants, burst-master state encoding and the 4KB page-crossing helper.
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, ERR} state_e;

  // True when an INCR burst of len+1 beats starting at addr_lo runs past the 4KB page.
  function automatic logic crosses_4k(input logic [11:0] addr_lo, input logic [7:0] len,
                                      input int strb_width);
    int end_v;
    end_v = int'(addr_lo) + (int'(len) + 32'sd1) * strb_width;
    return (end_v > 32'sd4096);
  endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI4 master-slot bundle (AW/W/B/AR/R) between the burst master and an interconnect port.
interface axi_burst_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ID_WIDTH-1:0]   M_AWID;
  logic [ADDR_WIDTH-1:0] M_AWADDR;
  logic [7:0]            M_AWLEN;
  logic [2:0]            M_AWSIZE;
  logic [1:0]            M_AWBURST;
  logic                  M_AWLOCK;
  logic [3:0]            M_AWCACHE;
  logic [2:0]            M_AWPROT;
  logic [3:0]            M_AWQOS;
  logic [3:0]            M_AWREGION;
  logic [USER_WIDTH-1:0] M_AWUSER;
  logic                  M_AWVALID;
  logic                  M_AWREADY;

  logic [DATA_WIDTH-1:0] M_WDATA;
  logic [STRB_WIDTH-1:0] M_WSTRB;
  logic                  M_WLAST;
  logic [USER_WIDTH-1:0] M_WUSER;
  logic                  M_WVALID;
  logic                  M_WREADY;

  logic [ID_WIDTH-1:0]   M_BID;
  logic [1:0]            M_BRESP;
  logic                  M_BVALID;
  logic                  M_BREADY;

  logic [ID_WIDTH-1:0]   M_ARID;
  logic [ADDR_WIDTH-1:0] M_ARADDR;
  logic [7:0]            M_ARLEN;
  logic [2:0]            M_ARSIZE;
  logic [1:0]            M_ARBURST;
  logic                  M_ARLOCK;
  logic [3:0]            M_ARCACHE;
  logic [2:0]            M_ARPROT;
  logic [3:0]            M_ARQOS;
  logic [3:0]            M_ARREGION;
  logic [USER_WIDTH-1:0] M_ARUSER;
  logic                  M_ARVALID;
  logic                  M_ARREADY;

  logic [ID_WIDTH-1:0]   M_RID;
  logic [DATA_WIDTH-1:0] M_RDATA;
  logic [1:0]            M_RRESP;
  logic                  M_RLAST;
  logic                  M_RVALID;
  logic                  M_RREADY;

  modport master (
    output M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWLOCK, M_AWCACHE, M_AWPROT,
           M_AWQOS, M_AWREGION, M_AWUSER, M_AWVALID,
    input  M_AWREADY,
    output M_WDATA, M_WSTRB, M_WLAST, M_WUSER, M_WVALID,
    input  M_WREADY,
    input  M_BID, M_BRESP, M_BVALID,
    output M_BREADY,
    output M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARLOCK, M_ARCACHE, M_ARPROT,
           M_ARQOS, M_ARREGION, M_ARUSER, M_ARVALID,
    input  M_ARREADY,
    input  M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID,
    output M_RREADY
  );

  modport slave (
    input  M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWLOCK, M_AWCACHE, M_AWPROT,
           M_AWQOS, M_AWREGION, M_AWUSER, M_AWVALID,
    output M_AWREADY,
    input  M_WDATA, M_WSTRB, M_WLAST, M_WUSER, M_WVALID,
    output M_WREADY,
    output M_BID, M_BRESP, M_BVALID,
    input  M_BREADY,
    input  M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARLOCK, M_ARCACHE, M_ARPROT,
           M_ARQOS, M_ARREGION, M_ARUSER, M_ARVALID,
    output M_ARREADY,
    output M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID,
    input  M_RREADY
  );

endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst engine: one command becomes one AW/W/B or AR/R transaction.
// Beat data passes combinationally; control state, burst context and completion are registered.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MASTER_ID  = 0
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  done,
  output logic                  done_err,
  axi_burst_master_if.master    m
);

  localparam int SIZE = $clog2(STRB_WIDTH);
  localparam logic [ID_WIDTH-1:0] MID_C = ID_WIDTH'(MASTER_ID);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  done_err_q, done_err_d;

  logic [ADDR_WIDTH-1:0] aligned_s;
  logic                  last_cnt_s;
  logic                  w_hs_s;
  logic                  r_hs_s;
  logic                  r_beat_err_s;

  assign aligned_s    = {cmd_addr[ADDR_WIDTH-1:SIZE], {SIZE{1'b0}}};
  assign last_cnt_s   = (cnt_q == len_q);
  assign w_hs_s       = (state_q == W) && wr_valid && m.M_WREADY;
  assign r_hs_s       = (state_q == R) && m.M_RVALID && rd_ready;
  // A misplaced or missing RLAST is flagged the same way as a bad response or ID.
  assign r_beat_err_s = (m.M_RRESP != RESP_OKAY) || (m.M_RID != MID_C) ||
                        (m.M_RLAST != last_cnt_s);

  // State and burst-context registers; reset clears every handshake driver at once.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      addr_q     <= {ADDR_WIDTH{1'b0}};
      len_q      <= 8'd0;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

  // Next-state, beat counting and completion status.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = aligned_s;
          len_d  = cmd_len;
          cnt_d  = 8'd0;
          err_d  = 1'b0;
          if (crosses_4k(aligned_s[11:0], cmd_len, STRB_WIDTH)) begin
            state_d = ERR;
          end else if (cmd_write) begin
            state_d = AW;
          end else begin
            state_d = AR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      AW: begin
        if (m.M_AWREADY) state_d = W;
        else             state_d = AW;
      end
      W: begin
        if (w_hs_s) begin
          cnt_d = cnt_q + 8'd1;
          if (last_cnt_s) state_d = B;
          else            state_d = W;
        end else begin
          state_d = W;
        end
      end
      B: begin
        if (m.M_BVALID) begin
          done_d     = 1'b1;
          done_err_d = (m.M_BRESP != RESP_OKAY) || (m.M_BID != MID_C);
          state_d    = IDLE;
        end else begin
          state_d = B;
        end
      end
      AR: begin
        if (m.M_ARREADY) state_d = R;
        else             state_d = AR;
      end
      R: begin
        if (r_hs_s) begin
          cnt_d = cnt_q + 8'd1;
          err_d = err_q | r_beat_err_s;
          if (m.M_RLAST) begin
            done_d     = 1'b1;
            done_err_d = err_q | r_beat_err_s;
            state_d    = IDLE;
          end else begin
            state_d = R;
          end
        end else begin
          state_d = R;
        end
      end
      ERR: begin
        done_d     = 1'b1;
        done_err_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign done      = done_q;
  assign done_err  = done_err_q;

  assign m.M_AWID     = MID_C;
  assign m.M_AWADDR   = addr_q;
  assign m.M_AWLEN    = len_q;
  assign m.M_AWSIZE   = 3'(SIZE);
  assign m.M_AWBURST  = BURST_INCR;
  assign m.M_AWLOCK   = 1'b0;
  assign m.M_AWCACHE  = 4'd0;
  assign m.M_AWPROT   = 3'd0;
  assign m.M_AWQOS    = 4'd0;
  assign m.M_AWREGION = 4'd0;
  assign m.M_AWUSER   = {USER_WIDTH{1'b0}};
  assign m.M_AWVALID  = (state_q == AW);

  assign m.M_WDATA  = wr_data;
  assign m.M_WSTRB  = {STRB_WIDTH{1'b1}};
  assign m.M_WLAST  = last_cnt_s;
  assign m.M_WUSER  = {USER_WIDTH{1'b0}};
  assign m.M_WVALID = (state_q == W) && wr_valid;
  assign wr_ready   = (state_q == W) && m.M_WREADY;
  assign m.M_BREADY = (state_q == B);

  assign m.M_ARID     = MID_C;
  assign m.M_ARADDR   = addr_q;
  assign m.M_ARLEN    = len_q;
  assign m.M_ARSIZE   = 3'(SIZE);
  assign m.M_ARBURST  = BURST_INCR;
  assign m.M_ARLOCK   = 1'b0;
  assign m.M_ARCACHE  = 4'd0;
  assign m.M_ARPROT   = 3'd0;
  assign m.M_ARQOS    = 4'd0;
  assign m.M_ARREGION = 4'd0;
  assign m.M_ARUSER   = {USER_WIDTH{1'b0}};
  assign m.M_ARVALID  = (state_q == AR);

  assign m.M_RREADY = (state_q == R) && rd_ready;
  assign rd_valid   = (state_q == R) && m.M_RVALID;
  assign rd_data    = m.M_RDATA;
  assign rd_last    = (state_q == R) && m.M_RLAST;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: a small slave model answers each burst and every
// test task compares what it observed against hand-computed values.
module tb_axi_burst_master;

  logic        ACLK;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [63:0] wr_data, rd_data;
  logic        wr_valid, wr_ready, rd_valid, rd_ready, rd_last;
  logic        done, done_err;

  axi_burst_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .USER_WIDTH(1)) bus ();

  axi_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .USER_WIDTH(1),
                     .MASTER_ID(0)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .done(done), .done_err(done_err), .m(bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int vecs, errs;
  logic [63:0] mem [64];

  // Observations of the most recent burst
  int          o_ax_cycles, o_ax_first, o_beats, o_last_beat, o_data_bad, o_flag_bad;
  int          o_wv_seen, o_done_cyc, o_lat;
  logic [31:0] o_ax_addr;
  logic [7:0]  o_ax_len;
  logic        o_acc, o_done, o_done_err, o_done2;

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0;
    wr_data = 64'd0; wr_valid = 1'b0; rd_ready = 1'b0;
    bus.M_AWREADY = 1'b0; bus.M_WREADY = 1'b0; bus.M_ARREADY = 1'b0;
    bus.M_BID = 4'd0; bus.M_BRESP = 2'b00; bus.M_BVALID = 1'b0;
    bus.M_RID = 4'd0; bus.M_RDATA = 64'd0; bus.M_RRESP = 2'b00; bus.M_RLAST = 1'b0;
    bus.M_RVALID = 1'b0;
  endtask

  task automatic clear_obs();
    o_ax_cycles = 0; o_ax_first = -1; o_beats = 0; o_last_beat = -1; o_data_bad = 0;
    o_flag_bad = 0; o_wv_seen = 0; o_done_cyc = -1; o_lat = -1; o_ax_addr = 32'hFFFF_FFFF;
    o_ax_len = 8'hFF; o_acc = 1'b0; o_done = 1'b0; o_done_err = 1'b0; o_done2 = 1'b0;
  endtask

  // Write burst: AWREADY after d AWVALID cycles, optional wr_valid gaps, BRESP br.
  task automatic run_write(input logic [31:0] a, input logic [7:0] l, input int d,
                           input logic [1:0] br, input logic [63:0] base, input bit gaps);
    int beat, bhs;
    bit bpend;
    clear_obs();
    beat = 0; bhs = -100; bpend = 1'b0;
    for (int cyc = 0; cyc < 120 && !o_done; cyc++) begin
      @(negedge ACLK);
      cmd_valid = (cyc == 0); cmd_write = 1'b1; cmd_addr = a; cmd_len = l;
      bus.M_AWREADY = (o_ax_cycles >= d);
      wr_valid = (beat <= int'(l)) && !(gaps && (cyc % 3 == 2));
      wr_data = base + 64'(beat);
      bus.M_WREADY = 1'b1;
      bus.M_BVALID = bpend; bus.M_BRESP = br; bus.M_BID = 4'd0;
      #1;
      if (cyc == 0) o_acc = cmd_ready;
      if (bus.M_AWVALID || bus.M_ARVALID) begin
        if (o_ax_cycles == 0) begin
          o_ax_first = cyc; o_ax_addr = bus.M_AWADDR; o_ax_len = bus.M_AWLEN;
        end else if (bus.M_AWADDR !== o_ax_addr || bus.M_AWLEN !== o_ax_len) begin
          o_flag_bad++;
        end
        o_ax_cycles++;
      end
      if (bus.M_WVALID) begin
        o_wv_seen++;
        if (wr_ready !== 1'b1) o_flag_bad++;
        if (bus.M_WDATA !== base + 64'(beat)) o_data_bad++;
        if (bus.M_WLAST !== (beat == int'(l))) o_flag_bad++;
        if (bus.M_WLAST) o_last_beat = beat;
        mem[(int'(a[8:3]) + beat) % 64] = bus.M_WDATA;
        beat++; o_beats = beat;
        if (beat > int'(l)) bpend = 1'b1;
      end
      if (bus.M_BVALID && bus.M_BREADY) begin bhs = cyc; bpend = 1'b0; end
      if (done) begin o_done = 1'b1; o_done_err = done_err; o_done_cyc = cyc; o_lat = cyc - bhs; end
    end
    idle_inputs();
    @(negedge ACLK); #1;
    o_done2 = done;
  endtask

  // Read burst: slave asserts RLAST on beat last_at; rd_ready optionally toggles 1/0.
  task automatic run_read(input logic [31:0] a, input logic [7:0] l, input int last_at,
                          input logic [1:0] rr, input logic [63:0] base, input bit tog);
    int beat, rhs;
    bit ar_done, fin;
    clear_obs();
    beat = 0; rhs = -100; ar_done = 1'b0; fin = 1'b0;
    for (int cyc = 0; cyc < 120 && !o_done; cyc++) begin
      @(negedge ACLK);
      cmd_valid = (cyc == 0); cmd_write = 1'b0; cmd_addr = a; cmd_len = l;
      bus.M_ARREADY = 1'b1;
      rd_ready = tog ? (cyc % 2 == 0) : 1'b1;
      bus.M_RVALID = ar_done && !fin;
      bus.M_RDATA = mem[(int'(a[8:3]) + beat) % 64];
      bus.M_RLAST = (beat == last_at); bus.M_RRESP = rr; bus.M_RID = 4'd0;
      #1;
      if (cyc == 0) o_acc = cmd_ready;
      if (bus.M_AWVALID || bus.M_ARVALID) begin
        if (o_ax_cycles == 0) begin
          o_ax_first = cyc; o_ax_addr = bus.M_ARADDR; o_ax_len = bus.M_ARLEN;
        end
        o_ax_cycles++;
        if (bus.M_ARREADY) ar_done = 1'b1;
      end
      if (bus.M_RVALID) begin
        if (rd_valid !== 1'b1 || bus.M_RREADY !== rd_ready) o_flag_bad++;
        if (bus.M_RREADY) begin
          if (rd_data !== base + 64'(beat)) o_data_bad++;
          if (rd_last !== bus.M_RLAST) o_flag_bad++;
          if (rd_last) o_last_beat = beat;
          rhs = cyc;
          if (bus.M_RLAST) fin = 1'b1;
          beat++; o_beats = beat;
        end
      end
      if (done) begin o_done = 1'b1; o_done_err = done_err; o_done_cyc = cyc; o_lat = cyc - rhs; end
    end
    idle_inputs();
    @(negedge ACLK); #1;
    o_done2 = done;
  endtask

  task automatic test_reset();
    logic [8:0] ctl;
    ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    #1;
    ctl = {bus.M_AWVALID, bus.M_ARVALID, bus.M_WVALID, bus.M_BREADY, bus.M_RREADY,
           wr_ready, rd_valid, done, done_err};
    vecs++; if (ctl !== 9'd0) begin errs++; $display("FAIL rst_ctl: got %b expected 0", ctl); end
    vecs++; if (bus.M_AWADDR !== 32'd0 || bus.M_AWLEN !== 8'd0) begin errs++; $display("FAIL rst_addr_len: got %h/%h expected 0/0", bus.M_AWADDR, bus.M_AWLEN); end
    vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
    @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  task automatic test_write_basic();
    run_write(32'h0, 8'd7, 3, 2'b00, 64'd0, 1'b1);
    vecs++; if (o_acc !== 1'b1) begin errs++; $display("FAIL wr_cmd_ready: got %b expected 1", o_acc); end
    vecs++; if (o_ax_first !== 1) begin errs++; $display("FAIL wr_aw_latency: got %0d expected 1", o_ax_first); end
    vecs++; if (o_ax_len !== 8'd7) begin errs++; $display("FAIL wr_awlen: got %0d expected 7", o_ax_len); end
    vecs++; if (o_ax_cycles !== 4) begin errs++; $display("FAIL wr_awvalid_cycles: got %0d expected 4", o_ax_cycles); end
    vecs++; if (o_beats !== 8 || o_data_bad !== 0) begin errs++; $display("FAIL wr_beats: got %0d beats %0d bad expected 8/0", o_beats, o_data_bad); end
    vecs++; if (o_last_beat !== 7 || o_flag_bad !== 0) begin errs++; $display("FAIL wr_wlast: got last %0d flags %0d expected 7/0", o_last_beat, o_flag_bad); end
    vecs++; if (o_done !== 1'b1 || o_done_err !== 1'b0) begin errs++; $display("FAIL wr_done: got %b/%b expected 1/0", o_done, o_done_err); end
    vecs++; if (o_lat !== 1 || o_done2 !== 1'b0) begin errs++; $display("FAIL wr_done_timing: got lat %0d after %b expected 1/0", o_lat, o_done2); end
  endtask

  task automatic test_read_basic();
    run_read(32'h0, 8'd7, 7, 2'b00, 64'd0, 1'b1);
    vecs++; if (o_ax_first !== 1 || o_ax_len !== 8'd7) begin errs++; $display("FAIL rd_ar: got first %0d len %0d expected 1/7", o_ax_first, o_ax_len); end
    vecs++; if (o_beats !== 8 || o_data_bad !== 0) begin errs++; $display("FAIL rd_data: got %0d beats %0d bad expected 8/0", o_beats, o_data_bad); end
    vecs++; if (o_last_beat !== 7 || o_flag_bad !== 0) begin errs++; $display("FAIL rd_last_rready: got last %0d flags %0d expected 7/0", o_last_beat, o_flag_bad); end
    vecs++; if (o_done !== 1'b1 || o_done_err !== 1'b0 || o_lat !== 1) begin errs++; $display("FAIL rd_done: got %b/%b lat %0d expected 1/0/1", o_done, o_done_err, o_lat); end
  endtask

  task automatic test_4k_boundary();
    run_write(32'hFC8, 8'd7, 0, 2'b00, 64'd100, 1'b0);
    vecs++; if (o_ax_cycles !== 0 || o_wv_seen !== 0) begin errs++; $display("FAIL k4_no_bus: got ax %0d w %0d expected 0/0", o_ax_cycles, o_wv_seen); end
    vecs++; if (o_done !== 1'b1 || o_done_err !== 1'b1) begin errs++; $display("FAIL k4_done: got %b/%b expected 1/1", o_done, o_done_err); end
    vecs++; if (o_done_cyc !== 2 || o_done2 !== 1'b0) begin errs++; $display("FAIL k4_timing: got cyc %0d after %b expected 2/0", o_done_cyc, o_done2); end
    run_write(32'hFC0, 8'd7, 0, 2'b00, 64'd200, 1'b0);
    vecs++; if (o_beats !== 8 || o_done_err !== 1'b0) begin errs++; $display("FAIL k4_exact_fit: got %0d beats err %b expected 8/0", o_beats, o_done_err); end
  endtask

  task automatic test_bresp_err();
    run_write(32'h100, 8'd3, 0, 2'b10, 64'd50, 1'b0);
    vecs++; if (o_done !== 1'b1 || o_done_err !== 1'b1) begin errs++; $display("FAIL bresp_err: got %b/%b expected 1/1", o_done, o_done_err); end
  endtask

  task automatic test_rlast_early();
    run_read(32'h0, 8'd7, 5, 2'b00, 64'd0, 1'b0);
    vecs++; if (o_beats !== 6) begin errs++; $display("FAIL rlast_early_beats: got %0d expected 6", o_beats); end
    vecs++; if (o_done !== 1'b1 || o_done_err !== 1'b1) begin errs++; $display("FAIL rlast_early_err: got %b/%b expected 1/1", o_done, o_done_err); end
  endtask

  task automatic test_align_len0();
    run_write(32'h43, 8'd0, 1, 2'b00, 64'hABCD, 1'b0);
    vecs++; if (o_ax_addr !== 32'h40) begin errs++; $display("FAIL align_awaddr: got %h expected 00000040", o_ax_addr); end
    vecs++; if (o_beats !== 1 || o_last_beat !== 0 || o_flag_bad !== 0) begin errs++; $display("FAIL len0_beat: got %0d beats last %0d flags %0d expected 1/0/0", o_beats, o_last_beat, o_flag_bad); end
    vecs++; if (o_done !== 1'b1 || o_done_err !== 1'b0) begin errs++; $display("FAIL len0_done: got %b/%b expected 1/0", o_done, o_done_err); end
  endtask

  task automatic test_reset_mid_burst();
    int  beats;
    logic pre_wv, post_v, any_done;
    beats = 0; pre_wv = 1'b0; any_done = 1'b0;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h200; cmd_len = 8'd7;
    bus.M_AWREADY = 1'b1; bus.M_WREADY = 1'b1; wr_valid = 1'b1; wr_data = 64'd0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge ACLK);
      cmd_valid = 1'b0; wr_data = 64'(beats);
      #1;
      if (done) any_done = 1'b1;
      if (bus.M_WVALID) begin
        if (beats == 4) begin pre_wv = 1'b1; break; end
        beats++;
      end
    end
    ARESETn = 1'b0;
    #1;
    post_v = bus.M_WVALID | bus.M_AWVALID | wr_ready;
    vecs++; if (pre_wv !== 1'b1 || post_v !== 1'b0) begin errs++; $display("FAIL rst_mid_valid: got before %b after %b expected 1/0", pre_wv, post_v); end
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    idle_inputs();
    #1;
    vecs++; if (cmd_ready !== 1'b1 || bus.M_AWLEN !== 8'd0) begin errs++; $display("FAIL rst_mid_idle: got ready %b len %0d expected 1/0", cmd_ready, bus.M_AWLEN); end
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge ACLK); #1;
      if (done) any_done = 1'b1;
    end
    vecs++; if (any_done !== 1'b0) begin errs++; $display("FAIL rst_mid_no_done: got %b expected 0", any_done); end
  endtask

  initial begin
    vecs = 0; errs = 0;
    for (int i = 0; i < 64; i++) mem[i] = 64'hDEAD_0000_0000_0000 + 64'(i);
    idle_inputs();
    ARESETn = 1'b0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_4k_boundary();
    test_bresp_err();
    test_rlast_early();
    test_align_len0();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
